// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between a controlling FSM (master)
// and the bit-serial subtractor (slave).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full subtractor plus a borrow flip-flop.
// Result is valid from the done pulse until the next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave sif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, diff_q, diff_nxt;
  logic [CW-1:0]    cnt;
  logic             bf, a_msb, b_msb;
  logic             done_q, borrow_q, ovf_q;
  logic             accept, last, busy_o;
  logic             d, bo;

  // Half subtractor: {borrow, difference}
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    half_sub = {~x & y, x ^ y};
  endfunction

  // Full subtractor as two cascaded half subtractors
  logic [1:0] hs1, hs2;
  always_comb begin
    hs1      = half_sub(sa[0], sb[0]);
    hs2      = half_sub(hs1[0], bf);
    d        = hs2[0];
    bo       = hs1[1] | hs2[1];
    diff_nxt = diff_q >> 1;
    diff_nxt[WIDTH-1] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sif.start)   state_n = RUN;
      RUN:     if (cnt == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    busy_o = 1'b0;
    case (state)
      IDLE: accept = sif.start;
      RUN: begin
        busy_o = 1'b1;
        last   = (cnt == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bf       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        sa    <= sif.a;
        sb    <= sif.b;
        bf    <= 1'b0;
        cnt   <= '0;
        a_msb <= sif.a[WIDTH-1];
        b_msb <= sif.b[WIDTH-1];
      end else if (busy_o) begin
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        diff_q <= diff_nxt;
        bf     <= bo;
        cnt    <= cnt + CW'(1);
        // The final d is the result MSB, so overflow is decided on this edge
        if (last) begin
          done_q   <= 1'b1;
          borrow_q <= bo;
          ovf_q    <= (a_msb != b_msb) && (d != a_msb);
        end
      end
    end
  end

  assign sif.busy       = busy_o;
  assign sif.done       = done_q;
  assign sif.diff       = diff_q;
  assign sif.borrow_out = borrow_q;
  assign sif.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=8 and WIDTH=1
// against plain arithmetic a - b.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) s8 ();
  serial_subtractor_if #(.WIDTH(1)) s1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sif(s8.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .sif(s1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, bounded; returns cycles from the accept sample and busy samples seen
  task automatic wait_done8(input int lim, output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (s8.done !== 1'b1 && cyc < lim) begin
      if (s8.busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic [7:0] ed;
    logic       eb, eo;
    int         cyc, bcnt;
    ed = av - bv;
    eb = (av < bv);
    eo = (av[7] != bv[7]) && (ed[7] != av[7]);
    s8.start = 1'b1; s8.a = av; s8.b = bv;
    tick();
    s8.start = 1'b0; s8.a = 8'($urandom); s8.b = 8'($urandom);
    wait_done8(12, cyc, bcnt);
    chk({tag, "_lat"},  32'(cyc),  32'd8);
    chk({tag, "_busy"}, 32'(bcnt), 32'd8);
    chk({tag, "_diff"}, 32'(s8.diff), 32'(ed));
    chk({tag, "_bo"},   32'(s8.borrow_out), 32'(eb));
    chk({tag, "_ov"},   32'(s8.overflow), 32'(eo));
    tick();
    chk({tag, "_pulse"}, 32'(s8.done), 32'd0);
    chk({tag, "_hold"},  32'({s8.overflow, s8.borrow_out, s8.diff}), 32'({eo, eb, ed}));
  endtask

  task automatic op1(input logic av, input logic bv);
    logic ed, eb, eo;
    int   cyc;
    ed = av ^ bv;
    eb = ~av & bv;
    eo = (av != bv) && (ed != av);
    s1.start = 1'b1; s1.a = av; s1.b = bv;
    tick();
    s1.start = 1'b0;
    chk("w1_busy", 32'(s1.busy), 32'd1);
    cyc = 0;
    while (s1.done !== 1'b1 && cyc < 4) begin
      tick();
      cyc++;
    end
    chk("w1_lat", 32'(cyc), 32'd1);
    chk("w1_res", 32'({s1.overflow, s1.borrow_out, s1.diff}), 32'({eo, eb, ed}));
    tick();
    chk("w1_hold", 32'({s1.done, s1.overflow, s1.borrow_out, s1.diff}), 32'({1'b0, eo, eb, ed}));
  endtask

  initial begin
    logic [7:0] pa [5];
    logic [7:0] pb [5];
    logic [7:0] cap, ed;
    logic       capb;
    int         ndone, cyc, bcnt;

    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    s1.start = 1'b0; s1.a = '0; s1.b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", 32'({s8.busy, s8.done, s8.borrow_out, s8.overflow, s8.diff}), 32'd0);
    chk("rst_outs_w1", 32'({s1.busy, s1.done, s1.borrow_out, s1.overflow, s1.diff}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    op8(8'h5A, 8'h3C, "d5a3c");
    op8(8'h00, 8'h01, "d0001");
    op8(8'h80, 8'h01, "d8001");
    op8(8'h7F, 8'hFF, "d7fff");
    op8(8'hFF, 8'hFF, "dffff");

    // start during busy must be ignored
    s8.start = 1'b1; s8.a = 8'h10; s8.b = 8'h01;
    tick();
    s8.start = 1'b0;
    repeat (2) tick();
    s8.start = 1'b1; s8.a = 8'hFF; s8.b = 8'hFF;
    tick();
    s8.start = 1'b0;
    ndone = 0; cap = '0; capb = 1'b1;
    repeat (14) begin
      tick();
      if (s8.done === 1'b1) begin
        ndone++;
        cap  = s8.diff;
        capb = s8.borrow_out;
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_diff",  32'(cap),   32'h0F);
    chk("ign_bo",    32'(capb),  32'd0);

    // asynchronous reset mid-operation
    s8.start = 1'b1; s8.a = 8'hAA; s8.b = 8'h55;
    tick();
    s8.start = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'({s8.busy, s8.done, s8.borrow_out, s8.overflow, s8.diff}), 32'd0);
    #12 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      tick();
      if (s8.done === 1'b1) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'd0);
    op8(8'h03, 8'h05, "post_rst");

    // start held high: one operation every WIDTH+1 cycles
    pa = '{8'h12, 8'h34, 8'hF0, 8'h7F, 8'h01};
    pb = '{8'h34, 8'h12, 8'h0F, 8'h80, 8'h02};
    s8.start = 1'b1; s8.a = pa[0]; s8.b = pb[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      s8.a = pa[i+1]; s8.b = pb[i+1];
      ed = pa[i] - pb[i];
      wait_done8(12, cyc, bcnt);
      chk("held_lat",  32'(cyc), 32'd8);
      chk("held_diff", 32'(s8.diff), 32'(ed));
      chk("held_bo",   32'(s8.borrow_out), 32'(pa[i] < pb[i]));
      chk("held_ov",   32'(s8.overflow), 32'((pa[i][7] != pb[i][7]) && (ed[7] != pa[i][7])));
      tick();
      chk("held_stable", 32'(s8.diff), 32'(ed));
      chk("held_reacc",  32'(s8.busy), 32'd1);
    end
    s8.start = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom), "rnd8");
    op1(1'b0, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) op1(1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
